io_supply_seq_ctrl: RTL and testbench

//  Power-sequencing controller for one IO pad-ring supply segment (VDDIO/VSSIO supply cells).

---
 rtl/io_supply_seq_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_io_supply_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_supply_seq_ctrl.sv
// rtl/io_supply_seq_ctrl.sv - power-sequencing controller for one IO pad-ring supply segment
//
// Purpose:
//   Enables the VDDIO power switch, waits for VDDIO to ramp and settle, then
//   releases pad isolation. Power-down runs in reverse: clamp pads, open the
//   switch, wait for discharge. A ramp timeout (and, optionally, a brownout)
//   parks the segment in a sticky FAULT state.
//
// Optional feature:
//   IOSEQ_BROWNOUT_EN - when defined, a power-good input that stays low for two
//   consecutive cycles in SETTLE, ISO_REL or ON forces FAULT with code 2.
//
// Ports:
//   clk_i         always-on clock
//   rst_ni        asynchronous active-low reset
//   on_req_i      level request to power the segment
//   off_req_i     level request to power down (wins over on_req_i)
//   vdd_pgood_i   core VDD power-good (already synchronised)
//   vddio_pgood_i VDDIO power-good (already synchronised)
//   fault_clr_i   pulse, clears the sticky fault (only honoured in FAULT with on_req_i low)
//   io_en_o       VDDIO power-switch enable
//   iso_n_o       pad isolation release (0 = pads clamped)
//   ready_o       segment up, pads usable
//   fault_o       sticky fault flag
//   fault_code_o  0 none, 1 ramp timeout, 2 brownout
//   state_o       current state encoding (debug)

module io_supply_seq_ctrl #(
  parameter int CNT_W     = 16,
  parameter int T_RAMP_TO = 1000,
  parameter int T_SETTLE  = 64,
  parameter int T_ISO     = 8,
  parameter int T_DISCH   = 256
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       on_req_i,
  input  logic       off_req_i,
  input  logic       vdd_pgood_i,
  input  logic       vddio_pgood_i,
  input  logic       fault_clr_i,
  output logic       io_en_o,
  output logic       iso_n_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [1:0] fault_code_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_RAMP    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ISO_REL = 3'd3,
    ST_ON      = 3'd4,
    ST_ISO_SET = 3'd5,
    ST_DISCH   = 3'd6,
    ST_FAULT   = 3'd7
  } state_e;

  localparam logic [1:0] CODE_NONE     = 2'd0;
  localparam logic [1:0] CODE_RAMP_TO  = 2'd1;
  localparam logic [1:0] CODE_BROWNOUT = 2'd2;

  // Timed states exit on the last count so each one lasts exactly T cycles.
  localparam logic [CNT_W-1:0] RAMP_LAST   = CNT_W'(T_RAMP_TO - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(T_ISO - 1);
  localparam logic [CNT_W-1:0] DISCH_LAST  = CNT_W'(T_DISCH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic             io_en_q, io_en_d;
  logic             iso_n_q, iso_n_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             bo_trip;

`ifdef IOSEQ_BROWNOUT_EN
  // bad_q remembers that a supply was low last cycle while being monitored,
  // so a single-cycle glitch never trips; two in a row do.
  logic pg_low;
  logic mon_st;
  logic bad_q, bad_d;

  assign pg_low  = !vdd_pgood_i || !vddio_pgood_i;
  assign mon_st  = (state_q == ST_SETTLE) || (state_q == ST_ISO_REL) || (state_q == ST_ON);
  assign bad_d   = mon_st && pg_low;
  assign bo_trip = bad_d && bad_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bad_q <= 1'b0;
    end else begin
      bad_q <= bad_d;
    end
  end
`else
  // Without brownout monitoring, supplies are only looked at in OFF and RAMP.
  assign bo_trip = 1'b0;
`endif

  // Next-state logic. off_req_i is checked before any forward progress so a
  // simultaneous on/off request always behaves as an off request.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    case (state_q)
      ST_OFF: begin
        if (!off_req_i && on_req_i && vdd_pgood_i) begin
          state_d = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (off_req_i) begin
          state_d = ST_DISCH;
        end else if (vddio_pgood_i) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == RAMP_LAST) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_RAMP_TO;
        end
      end
      ST_SETTLE: begin
        if (bo_trip) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_BROWNOUT;
        end else if (off_req_i) begin
          // Pads were never released, so skip straight to discharge.
          state_d = ST_DISCH;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_ISO_REL;
        end
      end
      ST_ISO_REL: begin
        if (bo_trip) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_BROWNOUT;
        end else if (off_req_i) begin
          state_d = ST_ISO_SET;
        end else if (cnt_q == ISO_LAST) begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (bo_trip) begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_BROWNOUT;
        end else if (off_req_i) begin
          state_d = ST_ISO_SET;
        end
      end
      ST_ISO_SET: begin
        if (cnt_q == ISO_LAST) begin
          state_d = ST_DISCH;
        end
      end
      ST_DISCH: begin
        if (cnt_q == DISCH_LAST) begin
          state_d = ST_OFF;
        end
      end
      ST_FAULT: begin
        // Require on_req_i low so a clear cannot immediately re-power the segment.
        if (fault_clr_i && !on_req_i) begin
          state_d      = ST_OFF;
          fault_code_d = CODE_NONE;
        end
      end
      default: begin
        state_d      = ST_OFF;
        fault_code_d = CODE_NONE;
      end
    endcase
  end

  // Counter restarts on every state change and free-runs otherwise; only the
  // timed states look at it.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state and registered, so they move in
  // the same cycle the state register does.
  always_comb begin
    io_en_d = (state_d == ST_RAMP)    || (state_d == ST_SETTLE) ||
              (state_d == ST_ISO_REL) || (state_d == ST_ON)     ||
              (state_d == ST_ISO_SET);
    iso_n_d = (state_d == ST_ISO_REL) || (state_d == ST_ON);
    ready_d = (state_d == ST_ON);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      fault_code_q <= CODE_NONE;
      io_en_q      <= 1'b0;
      iso_n_q      <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_code_q <= fault_code_d;
      io_en_q      <= io_en_d;
      iso_n_q      <= iso_n_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign io_en_o      = io_en_q;
  assign iso_n_o      = iso_n_q;
  assign ready_o      = ready_q;
  assign fault_o      = fault_q;
  assign fault_code_o = fault_code_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_io_supply_seq_ctrl.sv
// tb/tb_io_supply_seq_ctrl.sv - directed self-checking bench for io_supply_seq_ctrl

module tb_io_supply_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       on_req;
  logic       off_req;
  logic       vdd_pgood;
  logic       vddio_pgood;
  logic       fault_clr;
  logic       io_en;
  logic       iso_n;
  logic       ready;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  io_supply_seq_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .on_req_i      (on_req),
    .off_req_i     (off_req),
    .vdd_pgood_i   (vdd_pgood),
    .vddio_pgood_i (vddio_pgood),
    .fault_clr_i   (fault_clr),
    .io_en_o       (io_en),
    .iso_n_o       (iso_n),
    .ready_o       (ready),
    .fault_o       (fault),
    .fault_code_o  (fault_code),
    .state_o       (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and land 1ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; on_req = 1'b0; off_req = 1'b0; vdd_pgood = 1'b1;
    vddio_pgood = 1'b0; fault_clr = 1'b0;
    #23;
    checks++;
    if ({io_en, iso_n, ready, fault, fault_code, state} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %h want 00", {io_en, iso_n, ready, fault, fault_code, state});
    end
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (state !== 3'd0 || io_en !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got state %0d io_en %b want 0 0", state, io_en);
    end
  endtask

  task automatic test_no_vdd();
    vdd_pgood = 1'b0; on_req = 1'b1;
    tick(3);
    checks++;
    if (state !== 3'd0 || io_en !== 1'b0) begin
      errors++; $display("FAIL no_vdd_stay_off: got state %0d io_en %b want 0 0", state, io_en);
    end
    on_req = 1'b0; vdd_pgood = 1'b1;
    tick(1);
  endtask

  task automatic test_power_up();
    vddio_pgood = 1'b0; on_req = 1'b1;
    tick(1);
    checks++;
    if (io_en !== 1'b1 || state !== 3'd1) begin
      errors++; $display("FAIL up_io_en: got io_en %b state %0d want 1 1", io_en, state);
    end
    tick(20);
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL up_still_ramp: got %0d want 1", state);
    end
    vddio_pgood = 1'b1;
    tick(64);
    checks++;
    if (iso_n !== 1'b0 || state !== 3'd2) begin
      errors++; $display("FAIL up_settle_end: got iso_n %b state %0d want 0 2", iso_n, state);
    end
    tick(1);
    checks++;
    if (iso_n !== 1'b1 || state !== 3'd3 || ready !== 1'b0) begin
      errors++; $display("FAIL up_iso_rel: got iso_n %b state %0d ready %b want 1 3 0", iso_n, state, ready);
    end
    tick(7);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL up_ready_early: got %b want 0", ready);
    end
    tick(1);
    checks++;
    if (ready !== 1'b1 || state !== 3'd4) begin
      errors++; $display("FAIL up_ready: got ready %b state %0d want 1 4", ready, state);
    end
  endtask

  task automatic test_on_hold();
    on_req = 1'b0;
    tick(5);
    checks++;
    if (state !== 3'd4 || ready !== 1'b1) begin
      errors++; $display("FAIL on_hold: got state %0d ready %b want 4 1", state, ready);
    end
  endtask

  task automatic test_power_down();
    off_req = 1'b1;
    tick(1);
    off_req = 1'b0;
    checks++;
    if (ready !== 1'b0 || iso_n !== 1'b0 || io_en !== 1'b1 || state !== 3'd5) begin
      errors++; $display("FAIL down_iso_set: got ready %b iso_n %b io_en %b state %0d want 0 0 1 5", ready, iso_n, io_en, state);
    end
    tick(7);
    checks++;
    if (io_en !== 1'b1) begin
      errors++; $display("FAIL down_io_en_early: got %b want 1", io_en);
    end
    tick(1);
    checks++;
    if (io_en !== 1'b0 || state !== 3'd6) begin
      errors++; $display("FAIL down_disch: got io_en %b state %0d want 0 6", io_en, state);
    end
    tick(255);
    checks++;
    if (state !== 3'd6) begin
      errors++; $display("FAIL down_disch_end: got %0d want 6", state);
    end
    tick(1);
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL down_off: got %0d want 0", state);
    end
  endtask

  task automatic test_ramp_timeout();
    vddio_pgood = 1'b0; on_req = 1'b1;
    tick(1);
    checks++;
    if (io_en !== 1'b1) begin
      errors++; $display("FAIL to_io_en: got %b want 1", io_en);
    end
    tick(999);
    checks++;
    if (fault !== 1'b0 || io_en !== 1'b1 || state !== 3'd1) begin
      errors++; $display("FAIL to_early: got fault %b io_en %b state %0d want 0 1 1", fault, io_en, state);
    end
    tick(1);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || io_en !== 1'b0 || state !== 3'd7 ||
        iso_n !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL to_fault: got fault %b code %0d io_en %b state %0d want 1 1 0 7", fault, fault_code, io_en, state);
    end
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    checks++;
    if (state !== 3'd7 || fault !== 1'b1) begin
      errors++; $display("FAIL to_clr_blocked: got state %0d fault %b want 7 1", state, fault);
    end
    on_req = 1'b0; fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0 || fault_code !== 2'd0) begin
      errors++; $display("FAIL to_clr: got state %0d fault %b code %0d want 0 0 0", state, fault, fault_code);
    end
  endtask

  task automatic test_abort_settle();
    vddio_pgood = 1'b1; on_req = 1'b1;
    tick(2);
    tick(10);
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("FAIL ab_settle: got %0d want 2", state);
    end
    off_req = 1'b1;
    tick(1);
    off_req = 1'b0;
    checks++;
    if (io_en !== 1'b0 || iso_n !== 1'b0 || state !== 3'd6) begin
      errors++; $display("FAIL ab_disch: got io_en %b iso_n %b state %0d want 0 0 6", io_en, iso_n, state);
    end
    tick(255);
    checks++;
    if (state !== 3'd6 || io_en !== 1'b0) begin
      errors++; $display("FAIL ab_on_ignored: got state %0d io_en %b want 6 0", state, io_en);
    end
    tick(1);
    on_req = 1'b0;
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL ab_off: got %0d want 0", state);
    end
    tick(1);
  endtask

  task automatic test_reset_iso_rel();
    on_req = 1'b1;
    tick(67);
    checks++;
    if (state !== 3'd3 || iso_n !== 1'b1) begin
      errors++; $display("FAIL rst_pre: got state %0d iso_n %b want 3 1", state, iso_n);
    end
    on_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (io_en !== 1'b0 || iso_n !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL rst_async: got io_en %b iso_n %b ready %b want 0 0 0", io_en, iso_n, ready);
    end
    #2 rst_n = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd0 || io_en !== 1'b0) begin
      errors++; $display("FAIL rst_after: got state %0d io_en %b want 0 0", state, io_en);
    end
  endtask

  task automatic test_brownout();
    vddio_pgood = 1'b1; on_req = 1'b1;
    tick(74);
    on_req = 1'b0;
    checks++;
    if (state !== 3'd4) begin
      errors++; $display("FAIL bo_on: got %0d want 4", state);
    end
    vddio_pgood = 1'b0;
    tick(1);
    vddio_pgood = 1'b1;
    tick(2);
    checks++;
    if (state !== 3'd4 || ready !== 1'b1) begin
      errors++; $display("FAIL bo_glitch: got state %0d ready %b want 4 1", state, ready);
    end
    vddio_pgood = 1'b0;
    tick(1);
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL bo_first_low: got %b want 1", ready);
    end
    tick(1);
    vddio_pgood = 1'b1;
`ifdef IOSEQ_BROWNOUT_EN
    checks++;
    if (fault_code !== 2'd2 || io_en !== 1'b0 || iso_n !== 1'b0 || state !== 3'd7) begin
      errors++; $display("FAIL bo_fault: got code %0d io_en %b iso_n %b state %0d want 2 0 0 7", fault_code, io_en, iso_n, state);
    end
`else
    checks++;
    if (ready !== 1'b1 || state !== 3'd4) begin
      errors++; $display("FAIL bo_ignored: got ready %b state %0d want 1 4", ready, state);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_no_vdd();
    test_power_up();
    test_on_hold();
    test_power_down();
    test_ramp_timeout();
    test_abort_settle();
    test_reset_iso_rel();
    test_brownout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
